// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide opcodes, MDU state encoding, iteration count.
package mips_pkg;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // True for the ops that occupy the iterative datapath.
  function automatic logic is_md_arith(input md_op_t op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the divide ops.
  function automatic logic is_md_div(input md_op_t op);
    logic r;
    case (op)
      MD_DIV, MD_DIVU: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_sign.sv
// Operand conditioning: magnitudes for the unsigned datapath plus the sign fixup flags.
module mdu_sign
  import mips_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  output logic        neg_res,
  output logic        neg_rem
);

  // Signed ops work on absolute values; the result/remainder are negated afterwards.
  always_comb begin
    a_mag   = rs_data;
    b_mag   = rt_data;
    neg_res = 1'b0;
    neg_rem = 1'b0;
    case (op)
      MD_MULT, MD_DIV: begin
        a_mag   = rs_data[31] ? (32'd0 - rs_data) : rs_data;
        b_mag   = rt_data[31] ? (32'd0 - rt_data) : rt_data;
        neg_res = rs_data[31] ^ rt_data[31];
        neg_rem = (op == MD_DIV) ? rs_data[31] : 1'b0;
      end
      default: begin
        a_mag   = rs_data;
        b_mag   = rt_data;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One radix-2 step per cycle for 32 cycles, then a fixup cycle that writes HI/LO.
module mdu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  md_op_t      op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rs_raw_q, rs_raw_d;
  logic        is_div_q, is_div_d;
  logic        div0_q, div0_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] a_mag_s, b_mag_s;
  logic        neg_res_s, neg_rem_s;
  logic [32:0] sum_s;
  logic [32:0] rem_sh_s;
  logic [63:0] prod_fix_s;

  mdu_sign u_sign (
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .a_mag   (a_mag_s),
    .b_mag   (b_mag_s),
    .neg_res (neg_res_s),
    .neg_rem (neg_rem_s)
  );

  // Next-state, datapath step and HI/LO write selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    a_d        = a_q;
    b_d        = b_q;
    rs_raw_d   = rs_raw_q;
    is_div_d   = is_div_q;
    div0_d     = div0_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sum_s      = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? a_q : 32'd0)};
    rem_sh_s   = {rem_q, quo_q[31]};
    prod_fix_s = neg_res_q ? (64'd0 - prod_q) : prod_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !flush) begin
          if (is_md_arith(op)) begin
            a_d       = a_mag_s;
            b_d       = b_mag_s;
            neg_res_d = neg_res_s;
            neg_rem_d = neg_rem_s;
            rs_raw_d  = rs_data;
            is_div_d  = is_md_div(op);
            div0_d    = (rt_data == 32'd0);
            prod_d    = {32'd0, b_mag_s};
            rem_d     = 32'd0;
            quo_d     = a_mag_s;
            cnt_d     = 5'd0;
            busy_d    = 1'b1;
            state_d   = RUN;
          end else if (op == MD_MTHI) begin
            hi_d = rs_data;
          end else if (op == MD_MTLO) begin
            lo_d = rs_data;
          end else begin
            hi_d = hi_q;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            // Restoring step: subtract only when the shifted remainder covers the divisor.
            if (rem_sh_s >= {1'b0, b_q}) begin
              rem_d = 32'(rem_sh_s - {1'b0, b_q});
              quo_d = {quo_q[30:0], 1'b1};
            end else begin
              rem_d = rem_sh_s[31:0];
              quo_d = {quo_q[30:0], 1'b0};
            end
          end else begin
            // Shift-add: multiplier bits consumed from the low end of the product.
            prod_d = {sum_s, prod_q[31:1]};
          end
          if (cnt_q == 5'(MD_ITER - 1)) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix_s[63:32];
            lo_d = prod_fix_s[31:0];
          end else if (div0_q) begin
            hi_d = rs_raw_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            lo_d = neg_res_q ? (32'd0 - quo_q) : quo_q;
            hi_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      prod_q    <= 64'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rs_raw_q  <= 32'd0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rs_raw_q  <= rs_raw_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit holding the architectural HI/LO registers of the MIPS R2000 pipeline. It consumes the operand pair that the EX stage forwards (rs/rt data after forwarding) together with a decoded multiply/divide opcode. It runs MULT/MULTU/DIV/DIVU over 32 iterations and applies MTHI/MTLO in a single cycle. `busy` drives the ID/EX hold logic so that a dependent MFHI/MFLO or a second MDU op stalls until the result is ready.

## Interface
Parameters:
- none; the iteration count is fixed by package constant `MD_ITER` = 32.

Ports:
- `clk`  in  1  the single pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  op request from EX; sampled only in IDLE.
- `op`  in  3  `md_op_t`: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- `rs_data`  in  32  operand A (multiplicand / dividend / MT source).
- `rt_data`  in  32  operand B (multiplier / divisor).
- `flush`  in  1  abort in-flight op (exception/flush from ID/EX).
- `busy`  out  1  high while an op is in RUN or FIX.
- `done`  out  1  one-cycle pulse when HI/LO receive a mult/div result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `start` + mult/div op + !`flush`:
  - latch the operand magnitudes (absolute value for MD_MULT/MD_DIV, raw value for the unsigned ops) plus two sign flags: result negate and remainder negate.
  - clear the iteration counter; go to RUN.
- IDLE + `start` + MD_MTHI/MD_MTLO + !`flush`: `hi` (or `lo`) ← `rs_data` at that edge. No busy, no done; stay in IDLE.
- RUN: one radix-2 step per cycle; counter 0..31; at count 31 go to FIX.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring; quotient bits shift in, 33-bit partial remainder.
- FIX: apply the sign fixups and write `hi`/`lo`; pulse `done`; return to IDLE.
  - Multiply: {hi,lo} ← product, negated in 64-bit two's complement if the signs differ (signed op only).
  - Divide: lo ← quotient, negated if the operand signs differ; hi ← remainder, negated if the dividend is negative.
- Divide by zero (rt_data = 0, signed or unsigned): hi ← rs_data, lo ← 32'hFFFF_FFFF, with the same latency and sign fixups suppressed.
- Signed overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF gives lo = 32'h8000_0000, hi = 0, with no trap.
- `start` while busy: ignored. Upstream must hold on `busy`.
- `flush` in RUN/FIX: next state IDLE; hi/lo unchanged; no done.
- `flush` together with `start` in IDLE: the request is dropped, including MT ops.
- `flush` in the same cycle as FIX: flush wins; no write, no done.
- Reset (any state, mid-op included): state IDLE, hi = lo = 0, busy = 0, done = 0, counter = 0.

## Timing
- `start` sampled at edge E0 → RUN from E0. Iterations occur at E1..E32, FIX is entered at E32, and the write happens at E33.
- `busy` is high in the 33 cycles following E0 and low again after E33.
- `done` is high and the new `hi`/`lo` are visible in the cycle after E33, i.e. 34 cycles after the start sample.
- A new `start` is accepted at E34 at the earliest. When `done` is asserted, busy is already low, so the next op may be presented in the same cycle as done.
- MTHI/MTLO: value visible the cycle after the sampling edge (latency 1).
- `busy` and `done` are registered outputs; no combinational path from any input to any output.

## Structure
- Shared package `mips_pkg` holds:
  - the `md_op_t` enum (3-bit) and `MD_ITER` = 32;
  - the state enum `md_state_t` {IDLE, RUN, FIX}, so that the ID hazard logic can reference it.
- One sub-module is natural: `mdu_sign`, a combinational block that computes operand magnitudes and the negate flags from op/rs/rt.
- The iteration datapath and FSM stay in `mdu`.

## Test plan
- MD_MULT, rs = 32'hFFFF_FFFD (−3), rt = 5 → done at cycle 34; hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFF1; busy high exactly 33 cycles.
- MD_MULTU, rs = rt = 32'hFFFF_FFFF → hi = 32'hFFFF_FFFE, lo = 32'h0000_0001.
- MD_DIV, rs = 32'hFFFF_FFF9 (−7), rt = 2 → lo = 32'hFFFF_FFFD, hi = 32'hFFFF_FFFF. Also DIV 32'h8000_0000 / 32'hFFFF_FFFF → lo = 32'h8000_0000, hi = 0.
- MD_DIVU, rs = 32'h1234_5678, rt = 0 → hi = 32'h1234_5678, lo = 32'hFFFF_FFFF, latency 34.
- MD_MTHI rs = 32'hA5A5_A5A5, then MD_MULTU 3×4, then a second `start` (MD_MTLO) at cycle 10 of the run → the MTLO is ignored; final hi = 0, lo = 12; done pulses once.
- Assert `flush` at cycle 15 of a DIV, then `rst` at cycle 20 of a following MULT → after the flush, hi/lo hold their prior values, there is no done, and busy drops the next cycle; after the reset, hi = lo = 0, busy = 0.
